// File: rtl/mem_burst_lanes.sv
// Byte-addressed memory of LANES byte-wide banks with per-lane row addressing,
// so any unaligned byte/half/word beat completes in one bank cycle; supports bursts.
module mem_burst_lanes #(
    parameter int unsigned ADDR_W     = 15,
    parameter int unsigned LANES      = 4,
    parameter int unsigned LEN_W      = 4,
    parameter int unsigned ALLOW_WRAP = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_write,
    input  logic [1:0]           req_size,
    input  logic                 req_signed,
    input  logic [ADDR_W-1:0]    req_addr,
    input  logic [LEN_W-1:0]     req_len,
    input  logic                 wr_valid,
    output logic                 wr_ready,
    input  logic [8*LANES-1:0]   wr_data,
    output logic                 rd_valid,
    output logic [8*LANES-1:0]   rd_data,
    output logic                 rd_last,
    output logic                 done,
    output logic                 err
);
    localparam int unsigned DW    = 8 * LANES;
    localparam int unsigned LB    = $clog2(LANES);
    localparam int unsigned ROW_W = ADDR_W - LB;
    localparam int unsigned ROWS  = 1 << ROW_W;
    localparam int unsigned EW    = ADDR_W + LEN_W + 4;

    typedef enum logic [1:0] {IDLE, WRITE, READ, FIN} state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [LEN_W-1:0]    cnt_q, cnt_d;
    logic [1:0]          size_q, size_d;
    logic                sgn_q, sgn_d;
    logic                req_ready_q, req_ready_d;
    logic                wr_ready_q, wr_ready_d;
    logic                rd_valid_q, rd_valid_d;
    logic                rd_last_q, rd_last_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic [LB-1:0]       rd_off_q, rd_off_d;
    logic [1:0]          rd_size_q, rd_size_d;
    logic                rd_sgn_q, rd_sgn_d;

    logic [EW-1:0]       span_c, last_byte_c;
    logic                req_bad_c;
    logic [31:0]         beat_bytes_c;
    logic                wr_fire_c, rd_issue_c;

    logic [LB-1:0]       lane_k_c     [LANES];
    logic [ROW_W-1:0]    lane_row_c   [LANES];
    logic                lane_we_c    [LANES];
    logic [7:0]          lane_wdata_c [LANES];

    logic [7:0]          bank_mem  [LANES][ROWS];
    logic [7:0]          bank_rd_q [LANES];

    logic [31:0]         rd_bytes_c;
    logic                rd_fill_c;
    logic [DW-1:0]       rd_word_c;

    // Request legality: beat wider than the bus, or burst running off the top of memory
    always_comb begin
        span_c      = (EW'(req_len) + EW'(1)) << req_size;
        last_byte_c = EW'(req_addr) + span_c - EW'(1);
        req_bad_c   = (32'(req_size) > LB) ||
                      ((ALLOW_WRAP == 0) && ((last_byte_c >> ADDR_W) != '0));
    end

    assign beat_bytes_c = 32'(1) << size_q;

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        cnt_d      = cnt_q;
        size_d     = size_q;
        sgn_d      = sgn_q;
        err_d      = 1'b0;
        rd_valid_d = 1'b0;
        rd_last_d  = 1'b0;
        rd_off_d   = rd_off_q;
        rd_size_d  = rd_size_q;
        rd_sgn_d   = rd_sgn_q;
        wr_fire_c  = 1'b0;
        rd_issue_c = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req_valid && req_ready_q) begin
                    addr_d = req_addr;
                    cnt_d  = req_len;
                    size_d = req_size;
                    sgn_d  = req_signed;
                    if (req_bad_c) begin
                        err_d   = 1'b1;
                        state_d = FIN;
                    end else if (req_write) begin
                        state_d = WRITE;
                    end else begin
                        state_d = READ;
                    end
                end
            end
            WRITE: begin
                if (wr_valid) begin
                    wr_fire_c = !rst;
                    addr_d    = addr_q + ADDR_W'(beat_bytes_c);
                    if (cnt_q == '0) state_d = FIN;
                    else             cnt_d   = cnt_q - LEN_W'(1);
                end
            end
            READ: begin
                rd_issue_c = 1'b1;
                rd_valid_d = 1'b1;
                rd_last_d  = (cnt_q == '0);
                rd_off_d   = addr_q[LB-1:0];
                rd_size_d  = size_q;
                rd_sgn_d   = sgn_q;
                addr_d     = addr_q + ADDR_W'(beat_bytes_c);
                if (cnt_q == '0) state_d = FIN;
                else             cnt_d   = cnt_q - LEN_W'(1);
            end
            FIN: begin
                state_d = IDLE;
            end
        endcase
        req_ready_d = (state_d == IDLE);
        wr_ready_d  = (state_d == WRITE);
        done_d      = (state_d == FIN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            cnt_q       <= '0;
            size_q      <= '0;
            sgn_q       <= 1'b0;
            req_ready_q <= 1'b1;
            wr_ready_q  <= 1'b0;
            rd_valid_q  <= 1'b0;
            rd_last_q   <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            rd_off_q    <= '0;
            rd_size_q   <= '0;
            rd_sgn_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            cnt_q       <= cnt_d;
            size_q      <= size_d;
            sgn_q       <= sgn_d;
            req_ready_q <= req_ready_d;
            wr_ready_q  <= wr_ready_d;
            rd_valid_q  <= rd_valid_d;
            rd_last_q   <= rd_last_d;
            done_q      <= done_d;
            err_q       <= err_d;
            rd_off_q    <= rd_off_d;
            rd_size_q   <= rd_size_d;
            rd_sgn_q    <= rd_sgn_d;
        end
    end

    // Lane l holds beat byte k = l - A (mod LANES); lanes below the start offset use the next row
    always_comb begin
        for (int unsigned l = 0; l < LANES; l++) begin
            lane_k_c[l]     = LB'(l) - addr_q[LB-1:0];
            lane_row_c[l]   = addr_q[ADDR_W-1:LB] + ROW_W'(LB'(l) < addr_q[LB-1:0]);
            lane_we_c[l]    = wr_fire_c && (32'(lane_k_c[l]) < beat_bytes_c);
            lane_wdata_c[l] = 8'h00;
            for (int unsigned j = 0; j < LANES; j++) begin
                if (j == beat_bytes_c - 32'(1) - 32'(lane_k_c[l])) begin
                    lane_wdata_c[l] = wr_data[8*j +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int unsigned l = 0; l < LANES; l++) begin
            if (lane_we_c[l]) bank_mem[l][lane_row_c[l]] <= lane_wdata_c[l];
            if (rd_issue_c)   bank_rd_q[l] <= bank_mem[l][lane_row_c[l]];
        end
    end

    // Big-endian reassembly: result byte j comes from beat byte n-1-j; upper bytes extend
    always_comb begin
        rd_bytes_c = 32'(1) << rd_size_q;
        rd_fill_c  = rd_sgn_q && bank_rd_q[rd_off_q][7];
        rd_word_c  = '0;
        for (int unsigned j = 0; j < LANES; j++) begin
            if (j >= rd_bytes_c) rd_word_c[8*j +: 8] = {8{rd_fill_c}};
            else rd_word_c[8*j +: 8] = bank_rd_q[rd_off_q + LB'(rd_bytes_c - 32'(1) - j)];
        end
    end

    assign rd_data   = rd_valid_q ? rd_word_c : '0;
    assign req_ready = req_ready_q;
    assign wr_ready  = wr_ready_q;
    assign rd_valid  = rd_valid_q;
    assign rd_last   = rd_last_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_mem_burst_lanes.sv
// Directed bench for mem_burst_lanes: one non-wrapping instance and one wrapping
// instance share stimulus; sel_w steers requests and observation to the wrapping one.
module tb_mem_burst_lanes;
    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_write, req_signed, wr_valid, sel_w;
    logic [1:0]  req_size;
    logic [14:0] req_addr;
    logic [3:0]  req_len;
    logic [31:0] wr_data;

    logic        a_req_ready, a_wr_ready, a_rd_valid, a_rd_last, a_done, a_err;
    logic [31:0] a_rd_data;
    logic        w_req_ready, w_wr_ready, w_rd_valid, w_rd_last, w_done, w_err;
    logic [31:0] w_rd_data;

    logic        o_req_ready, o_wr_ready, o_rd_valid, o_rd_last, o_done, o_err;
    logic [31:0] o_rd_data;
    logic        a_req_valid, w_req_valid;

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] wbeat [16];
    logic [31:0] rexp  [16];

    always #5 clk = ~clk;

    assign a_req_valid = req_valid & ~sel_w;
    assign w_req_valid = req_valid & sel_w;
    assign o_req_ready = sel_w ? w_req_ready : a_req_ready;
    assign o_wr_ready  = sel_w ? w_wr_ready  : a_wr_ready;
    assign o_rd_valid  = sel_w ? w_rd_valid  : a_rd_valid;
    assign o_rd_last   = sel_w ? w_rd_last   : a_rd_last;
    assign o_done      = sel_w ? w_done      : a_done;
    assign o_err       = sel_w ? w_err       : a_err;
    assign o_rd_data   = sel_w ? w_rd_data   : a_rd_data;

    mem_burst_lanes #(.ADDR_W(15), .LANES(4), .LEN_W(4), .ALLOW_WRAP(0)) u_dut (
        .clk(clk), .rst(rst), .req_valid(a_req_valid), .req_ready(a_req_ready),
        .req_write(req_write), .req_size(req_size), .req_signed(req_signed),
        .req_addr(req_addr), .req_len(req_len), .wr_valid(wr_valid & ~sel_w),
        .wr_ready(a_wr_ready), .wr_data(wr_data), .rd_valid(a_rd_valid),
        .rd_data(a_rd_data), .rd_last(a_rd_last), .done(a_done), .err(a_err)
    );

    mem_burst_lanes #(.ADDR_W(15), .LANES(4), .LEN_W(4), .ALLOW_WRAP(1)) u_dut_wrap (
        .clk(clk), .rst(rst), .req_valid(w_req_valid), .req_ready(w_req_ready),
        .req_write(req_write), .req_size(req_size), .req_signed(req_signed),
        .req_addr(req_addr), .req_len(req_len), .wr_valid(wr_valid & sel_w),
        .wr_ready(w_wr_ready), .wr_data(wr_data), .rd_valid(w_rd_valid),
        .rd_data(w_rd_data), .rd_last(w_rd_last), .done(w_done), .err(w_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Starts and ends on a negedge; returns on the negedge after the accept edge
    task automatic issue_req(input logic w, input logic [1:0] size, input logic sgn,
                             input logic [14:0] addr, input logic [3:0] len);
        int n;
        req_valid = 1'b1; req_write = w; req_size = size; req_signed = sgn;
        req_addr = addr; req_len = len;
        n = 0;
        while (!o_req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("req_ready", 32'(o_req_ready), 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic write_burst(input logic [1:0] size, input logic [14:0] addr,
                               input logic [3:0] len, input int stall_at);
        issue_req(1'b1, size, 1'b0, addr, len);
        for (int i = 0; i <= int'(len); i++) begin
            if (i == stall_at) begin
                wr_valid = 1'b0;
                repeat (2) begin
                    check("wr_ready_stall", 32'(o_wr_ready), 32'd1);
                    check("done_stall", 32'(o_done), 32'd0);
                    @(negedge clk);
                end
            end
            check($sformatf("wr_ready[%0d]", i), 32'(o_wr_ready), 32'd1);
            wr_valid = 1'b1;
            wr_data  = wbeat[i];
            @(negedge clk);
        end
        wr_valid = 1'b0;
        check("wr_done", 32'(o_done), 32'd1);
        check("wr_err", 32'(o_err), 32'd0);
        check("wr_ready_fin", 32'(o_wr_ready), 32'd0);
        @(negedge clk);
    endtask

    task automatic read_burst(input logic [1:0] size, input logic sgn,
                              input logic [14:0] addr, input logic [3:0] len);
        issue_req(1'b0, size, sgn, addr, len);
        for (int i = 0; i <= int'(len); i++) begin
            @(negedge clk);
            check($sformatf("rd_valid[%0d]", i), 32'(o_rd_valid), 32'd1);
            check($sformatf("rd_data@%h[%0d]", addr, i), o_rd_data, rexp[i]);
            check($sformatf("rd_last[%0d]", i), 32'(o_rd_last), 32'(i == int'(len)));
            check($sformatf("rd_done[%0d]", i), 32'(o_done), 32'(i == int'(len)));
        end
        check("rd_err", 32'(o_err), 32'd0);
        @(negedge clk);
        check("rd_ready_back", 32'(o_req_ready), 32'd1);
        check("rd_valid_off", 32'(o_rd_valid), 32'd0);
    endtask

    task automatic err_req(input logic w, input logic [1:0] size,
                           input logic [14:0] addr, input logic [3:0] len);
        issue_req(w, size, 1'b0, addr, len);
        check("err_done", 32'(o_done), 32'd1);
        check("err_flag", 32'(o_err), 32'd1);
        check("err_no_rd", 32'(o_rd_valid), 32'd0);
        check("err_no_wr", 32'(o_wr_ready), 32'd0);
        @(negedge clk);
        check("err_ready_back", 32'(o_req_ready), 32'd1);
        check("err_clear", 32'(o_err), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; sel_w = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_signed = 1'b0;
        req_size = '0; req_addr = '0; req_len = '0; wr_valid = 1'b0; wr_data = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_req_ready", 32'(o_req_ready), 32'd1);
        check("rst_wr_ready", 32'(o_wr_ready), 32'd0);
        check("rst_rd_valid", 32'(o_rd_valid), 32'd0);
        check("rst_done", 32'(o_done), 32'd0);
        check("rst_err", 32'(o_err), 32'd0);
        check("rst_rd_data", o_rd_data, 32'd0);

        // Preload bytes 0x00..0x0F = 0x10..0x1F
        wbeat[0] = 32'h10111213; wbeat[1] = 32'h14151617;
        wbeat[2] = 32'h18191A1B; wbeat[3] = 32'h1C1D1E1F;
        write_burst(2'd2, 15'h0000, 4'd3, -1);
        rexp[0] = 32'h11121314;
        read_burst(2'd2, 1'b0, 15'h0001, 4'd0);

        // Unaligned half write, then signed/unsigned and neighbour reads
        wbeat[0] = 32'h0000BEEF;
        write_burst(2'd1, 15'h0003, 4'd0, -1);
        rexp[0] = 32'hFFFFBEEF; read_burst(2'd1, 1'b1, 15'h0003, 4'd0);
        rexp[0] = 32'h0000BEEF; read_burst(2'd1, 1'b0, 15'h0003, 4'd0);
        rexp[0] = 32'h12BEEF15; read_burst(2'd2, 1'b0, 15'h0002, 4'd0);
        rexp[0] = 32'hFFFFFFBE; read_burst(2'd0, 1'b1, 15'h0003, 4'd0);
        rexp[0] = 32'h00000015; read_burst(2'd0, 1'b1, 15'h0005, 4'd0);

        // Byte burst with a two-cycle stall; upper wr_data bits must be ignored
        wbeat[0] = 32'h123456A0; wbeat[1] = 32'hFFFFFFA1;
        wbeat[2] = 32'h000000A2; wbeat[3] = 32'h5A5A5AA3;
        write_burst(2'd0, 15'h0010, 4'd3, 2);
        rexp[0] = 32'hA0A1A2A3; read_burst(2'd2, 1'b0, 15'h0010, 4'd0);
        rexp[0] = 32'h00001E1F; rexp[1] = 32'h0000A0A1;
        read_burst(2'd1, 1'b0, 15'h000E, 4'd1);
        rexp[0] = 32'hFFFFFFA0; rexp[1] = 32'hFFFFFFA1;
        rexp[2] = 32'hFFFFFFA2; rexp[3] = 32'hFFFFFFA3;
        read_burst(2'd0, 1'b1, 15'h0010, 4'd3);

        // Range and size errors, plus the last legal word
        err_req(1'b0, 2'd2, 15'h7FFE, 4'd0);
        err_req(1'b0, 2'd3, 15'h0000, 4'd0);
        err_req(1'b1, 2'd0, 15'h7FFF, 4'd1);
        wbeat[0] = 32'hCAFEF00D;
        write_burst(2'd2, 15'h7FFC, 4'd0, -1);
        rexp[0] = 32'hCAFEF00D; read_burst(2'd2, 1'b0, 15'h7FFC, 4'd0);

        // Wrapping instance: word straddling the top of memory
        sel_w = 1'b1;
        wbeat[0] = 32'h01020304;
        write_burst(2'd2, 15'h7FFE, 4'd0, -1);
        rexp[0] = 32'h01020304; read_burst(2'd2, 1'b0, 15'h7FFE, 4'd0);
        rexp[0] = 32'h00000304; read_burst(2'd1, 1'b0, 15'h0000, 4'd0);
        rexp[0] = 32'h00000002; read_burst(2'd0, 1'b0, 15'h7FFF, 4'd0);
        sel_w = 1'b0;

        // Reset during the third beat of an 8-beat read
        issue_req(1'b0, 2'd2, 1'b0, 15'h0000, 4'd7);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_rd_valid", 32'(o_rd_valid), 32'd0);
        check("abort_rd_data", o_rd_data, 32'd0);
        check("abort_rd_last", 32'(o_rd_last), 32'd0);
        check("abort_done", 32'(o_done), 32'd0);
        check("abort_err", 32'(o_err), 32'd0);
        check("abort_wr_ready", 32'(o_wr_ready), 32'd0);
        check("abort_req_ready", 32'(o_req_ready), 32'd1);
        rexp[0] = 32'h1112BEEF; read_burst(2'd2, 1'b0, 15'h0001, 4'd0);
        rexp[0] = 32'hA0A1A2A3; read_burst(2'd2, 1'b0, 15'h0010, 4'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mem_burst_lanes.md
Name: mem_burst_lanes

Overview:
- Byte-addressed data/instruction memory built from LANES independent byte-wide banks, each with its own row address, so any unaligned access completes in one bank cycle.
- Adds transfer sizes (byte/half/word), sign extension, valid/ready request and write-data handshakes, incrementing bursts and range-error detection.
- Sits between the multicycle CPU control/datapath and storage, and replaces the fixed 4-lane word memory.

Parameters:
- ADDR_W, 15, byte-address width; total capacity is 2^ADDR_W bytes.
- LANES, 4, byte lanes (power of two, 2..8); data width DW = 8*LANES; LB = log2(LANES).
- LEN_W, 4, burst length field width; a burst has req_len+1 beats (1..2^LEN_W).
- ALLOW_WRAP, 0, 1 = addresses wrap modulo 2^ADDR_W; 0 = an access past the top of memory is an error.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when req_valid & req_ready.
- req_write  in  1  1 = write burst, 0 = read burst.
- req_size  in  2  beat size is 2^req_size bytes.
- req_signed  in  1  reads only: sign-extend a sub-DW beat.
- req_addr  in  ADDR_W  byte address of the first beat.
- req_len  in  LEN_W  beats minus one.
- wr_valid  in  1  write beat data present.
- wr_ready  out  1  write beat consumed when wr_valid & wr_ready.
- wr_data  in  DW  write beat, right-justified.
- rd_valid  out  1  read beat valid; no backpressure.
- rd_data  out  DW  read beat, right-justified, zero- or sign-extended.
- rd_last  out  1  marks the final read beat.
- done  out  1  one-cycle pulse when a burst completes.
- err  out  1  qualifies done: the burst was rejected.

Behaviour:
- Reset: state IDLE, all outputs 0, burst counters cleared. Bank contents are not cleared. Reset mid-burst aborts the burst; beats already written remain in memory.
- Byte order is big-endian. For an n-byte beat at address A, byte A is the most significant byte of the n-byte value. Byte A+k lives in lane (A+k) mod LANES, at row (A+k)>>LB.
  - Lane row: row = (A>>LB) + (lane < A[LB-1:0] ? 1 : 0).
  - Wrap: the row wraps modulo 2^(ADDR_W-LB).
- Banks: synchronous write with per-lane enable, synchronous read (data one cycle after the address edge). Only lanes covered by the beat are write-enabled.
- States: IDLE, WRITE, READ, FIN.
  - req_ready = 1 only in IDLE.
  - Accept: the request is latched and the error check is run.
    - error → FIN with err = 1.
    - otherwise write → WRITE; read → READ.
- Error conditions, checked at accept:
  - 2^req_size > LANES.
  - ALLOW_WRAP = 0 and req_addr + (req_len+1)*2^req_size - 1 > 2^ADDR_W - 1.
  - An errored burst touches no bank and asserts no wr_ready or rd_valid.
- WRITE:
  - wr_ready = 1.
  - Each wr_valid cycle writes one beat at the clock edge, then the address advances by 2^req_size.
  - wr_valid low stalls with no bank enable.
  - After the last beat → FIN.
- READ:
  - Issues one beat address per cycle for req_len+1 cycles.
  - rd_valid for beat i is high in the cycle after beat i is issued; rd_last is set on the last beat.
  - After the last issue → FIN.
  - rd_data bits above the beat width are filled with 0, or with the beat MSB when req_signed = 1.
- FIN:
  - done = 1 for exactly one cycle.
  - For reads, this is the same cycle as the last rd_valid.
  - Next state is IDLE.
- Latency:
  - Single-beat read: accept edge, issue edge, then rd_valid and done in the following cycle; req_ready returns the next cycle.
  - Write: done is asserted the cycle after the last beat is written.
- req_size/req_signed ignored on writes beyond lane selection; wr_data bits above beat width ignored.

Test Plan:
- Preload bytes 0x00..0x0F = 0x10..0x1F; read size=2, addr 0x001, len 0 → one rd_valid, rd_data 0x11121314, rd_last = 1, done = 1, err = 0.
- Write size=1, addr 0x003, wr_data 0x0000BEEF → only bytes 3 = 0xBE and 4 = 0xEF change. Then read size=1 signed at addr 3 → 0xFFFFBEEF; unsigned → 0x0000BEEF.
- Write burst size=0, addr 0x10, len 3, data 0xA0..0xA3, with wr_valid low for 2 cycles mid-burst → 4 writes, stall honoured. Read burst size=2, addr 0x10 → 0xA0A1A2A3 with rd_last.
- ALLOW_WRAP = 0: read size=2, addr 0x7FFE → done with err = 1, no rd_valid. Size=3 with LANES = 4 → err = 1.
- ALLOW_WRAP = 1: write word 0x01020304 at 0x7FFE → bytes 0x7FFE = 01, 0x7FFF = 02, 0x0000 = 03, 0x0001 = 04.
- Assert rst during the 3rd beat of an 8-beat read → next cycle all outputs 0, req_ready = 1. A read of the earlier write data is intact.
